// File: rtl/signal_phase_scheduler.sv
// Timed phase scheduler for a highway / country-road intersection with a pedestrian crossing.
// Moore lamp outputs are decoded from the state register; dwell is measured by a per-state timer.
module signal_phase_scheduler #(
    parameter int CW       = 8,
    parameter int HW_MIN_T = 10,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int CW_MAX_T = 20,
    parameter int PED_T    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic       ped_req,
    output logic [1:0] hw,
    output logic [1:0] cw,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5,
        PW  = 3'd6
    } state_t;

    localparam logic [CW-1:0] HW_LAST  = CW'(HW_MIN_T - 1);
    localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AR_LAST  = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] CG_LAST  = CW'(CW_MAX_T - 1);
    localparam logic [CW-1:0] PED_LAST = CW'(PED_T - 1);
    localparam logic [CW-1:0] TMR_MAX  = '1;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] timer;
    logic [CW-1:0] timer_next;
    logic          ped_pend;
    logic          ped_pend_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= HG;
            timer    <= '0;
            ped_pend <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            ped_pend <= ped_pend_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HG:  if (timer >= HW_LAST && (x || ped_pend)) state_next = HY;
            HY:  if (timer == YEL_LAST) state_next = AR1;
            // Pedestrian wins over the country road when both are waiting.
            AR1: if (timer == AR_LAST) state_next = ped_pend ? PW : CG;
            CG:  if (!x || timer == CG_LAST) state_next = CY;
            CY:  if (timer == YEL_LAST) state_next = AR2;
            PW:  if (timer == PED_LAST) state_next = AR2;
            AR2: if (timer == AR_LAST) state_next = HG;
            default: state_next = HG;
        endcase
    end

    always_comb begin
        timer_next = timer + CW'(1);
        if (state_next != state) begin
            timer_next = '0;
        end else if (timer == TMR_MAX) begin
            // Only HG can dwell long enough to reach the top; hold there.
            timer_next = timer;
        end
    end

    always_comb begin
        ped_pend_next = ped_pend;
        if (state_next == PW && state != PW) begin
            ped_pend_next = 1'b0;
        end else if (ped_req && state != PW) begin
            ped_pend_next = 1'b1;
        end
    end

    always_comb begin
        hw      = 2'b00;
        cw      = 2'b00;
        walk    = 1'b0;
        ped_ack = 1'b0;
        phase   = state;
        case (state)
            HG: hw = 2'b10;
            HY: hw = 2'b01;
            CG: cw = 2'b10;
            CY: cw = 2'b01;
            PW: begin
                walk    = 1'b1;
                ped_ack = (timer == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Bench for signal_phase_scheduler: directed scenarios plus a randomized run,
// each cycle compared against an elapsed-time reference model of the intersection rules.
module tb_signal_phase_scheduler;

    localparam int HW_MIN_T = 10;
    localparam int YELLOW_T = 3;
    localparam int ALLRED_T = 2;
    localparam int CW_MAX_T = 20;
    localparam int PED_T    = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] hw;
    logic [1:0] cw;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase index, cycles already spent in it, pending pedestrian call.
    int m_ph   = 0;
    int m_cnt  = 0;
    bit m_pend = 1'b0;

    int seq[$];
    int exp_ph[$];
    int exp_len[$];

    signal_phase_scheduler #(
        .CW(8), .HW_MIN_T(HW_MIN_T), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
        .CW_MAX_T(CW_MAX_T), .PED_T(PED_T)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .ped_req(ped_req),
        .hw(hw), .cw(cw), .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs that the edge will sample.
    task automatic model_step(input bit r, input bit xv, input bit pv);
        int  nxt;
        int  elapsed;
        if (!r) begin
            m_ph = 0; m_cnt = 0; m_pend = 0;
            return;
        end
        elapsed = m_cnt + 1;
        nxt = m_ph;
        case (m_ph)
            0: if (elapsed >= HW_MIN_T && (xv || m_pend)) nxt = 1;
            1: if (elapsed == YELLOW_T) nxt = 2;
            2: if (elapsed == ALLRED_T) nxt = m_pend ? 6 : 3;
            3: if (!xv || elapsed == CW_MAX_T) nxt = 4;
            4: if (elapsed == YELLOW_T) nxt = 5;
            6: if (elapsed == PED_T) nxt = 5;
            5: if (elapsed == ALLRED_T) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt == 6 && m_ph != 6) m_pend = 0;
        else if (pv && m_ph != 6) m_pend = 1;
        if (nxt != m_ph) m_cnt = 0;
        else if (m_cnt < 255) m_cnt = m_cnt + 1;
        m_ph = nxt;
    endtask

    task automatic check_model();
        chk("phase", int'(phase), m_ph);
        chk("hw", int'(hw), (m_ph == 0) ? 2 : (m_ph == 1) ? 1 : 0);
        chk("cw", int'(cw), (m_ph == 3) ? 2 : (m_ph == 4) ? 1 : 0);
        chk("walk", int'(walk), (m_ph == 6) ? 1 : 0);
        chk("ped_ack", int'(ped_ack), (m_ph == 6 && m_cnt == 0) ? 1 : 0);
    endtask

    task automatic cycle(input bit r, input bit xv, input bit pv);
        reset = r; x = xv; ped_req = pv;
        model_step(r, xv, pv);
        @(posedge clk);
        #1;
        check_model();
        seq.push_back(int'(phase));
    endtask

    // Split the recorded phase trace into runs and compare against exp_ph/exp_len (len<0: don't care).
    task automatic check_runs(input string tag);
        int rp[$];
        int rl[$];
        int last;
        for (int i = 0; i < seq.size(); i++) begin
            if (i == 0 || seq[i] != seq[i-1]) begin
                rp.push_back(seq[i]);
                rl.push_back(1);
            end else begin
                last = rl.size() - 1;
                rl[last] = rl[last] + 1;
            end
        end
        for (int k = 0; k < exp_ph.size(); k++) begin
            if (k >= rp.size()) begin
                n_assert++;
                n_fail++;
                $error("FAIL %s_missing_run: observed %0d runs expected at least %0d", tag, rp.size(), k + 1);
                break;
            end
            chk({tag, "_run_phase"}, rp[k], exp_ph[k]);
            if (exp_len[k] > 0) chk({tag, "_run_len"}, rl[k], exp_len[k]);
        end
    endtask

    initial begin
        int walk_cnt;
        int ack_cnt;
        int ack_at;
        bit found;
        bit xr;

        // 1: idle highway green
        cycle(0, 0, 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_hw", int'(hw), 2);
        chk("rst_cw", int'(cw), 0);
        chk("rst_walk", int'(walk), 0);
        chk("rst_ack", int'(ped_ack), 0);
        for (int i = 0; i < 50; i++) begin
            cycle(1, 0, 0);
            chk("idle_phase", int'(phase), 0);
            chk("idle_hw", int'(hw), 2);
        end

        // 2: country car always present, CG cut off at its maximum
        seq.delete();
        cycle(0, 1, 0);
        for (int i = 0; i < 59; i++) cycle(1, 1, 0);
        exp_ph  = {0, 1, 2, 3, 4, 5, 0, 1};
        exp_len = {HW_MIN_T, YELLOW_T, ALLRED_T, CW_MAX_T, YELLOW_T, ALLRED_T, HW_MIN_T, YELLOW_T};
        check_runs("xheld");

        // 3: one-cycle country request at cycle 15
        seq.delete();
        cycle(0, 0, 0);
        for (int i = 0; i < 15; i++) cycle(1, 0, 0);
        cycle(1, 1, 0);
        chk("xpulse_hy_start", int'(phase), 1);
        for (int i = 0; i < 30; i++) cycle(1, 0, 0);
        exp_ph  = {0, 1, 2, 3, 4, 5, 0};
        exp_len = {16, YELLOW_T, ALLRED_T, 1, YELLOW_T, ALLRED_T, -1};
        check_runs("xpulse");

        // 4: pedestrian pulse at cycle 2, second pulse during walk
        seq.delete();
        walk_cnt = 0; ack_cnt = 0; ack_at = -1;
        cycle(0, 0, 0);
        for (int c = 0; c < 60; c++) begin
            cycle(1, 0, (c == 2 || c == 17) ? 1'b1 : 1'b0);
            if (walk) walk_cnt++;
            if (ped_ack) begin
                ack_cnt++;
                ack_at = c + 1;
            end
        end
        chk("ped_walk_cycles", walk_cnt, PED_T);
        chk("ped_ack_count", ack_cnt, 1);
        chk("ped_ack_cycle", ack_at, 15);
        exp_ph  = {0, 1, 2, 6, 5, 0};
        exp_len = {HW_MIN_T, YELLOW_T, ALLRED_T, PED_T, ALLRED_T, -1};
        check_runs("ped");

        // 5: car and pedestrian together; walk served first
        seq.delete();
        cycle(0, 0, 0);
        cycle(1, 1, 1);
        for (int i = 0; i < 58; i++) cycle(1, 1, 0);
        exp_ph  = {0, 1, 2, 6, 5, 0, 1, 2, 3};
        exp_len = {HW_MIN_T, YELLOW_T, ALLRED_T, PED_T, ALLRED_T, HW_MIN_T, YELLOW_T, ALLRED_T, -1};
        check_runs("both");

        // 6: reset mid-CG with a pending walk request
        cycle(0, 1, 0);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle(1, 1, 0);
            if (m_ph == 3 && m_cnt == 2) found = 1;
        end
        chk("cg_reached", int'(found), 1);
        cycle(1, 1, 1);
        cycle(1, 1, 0);
        cycle(1, 1, 0);
        chk("mid_cg_phase", int'(phase), 3);
        cycle(0, 1, 0);
        chk("rst2_phase", int'(phase), 0);
        chk("rst2_hw", int'(hw), 2);
        chk("rst2_cw", int'(cw), 0);
        chk("rst2_walk", int'(walk), 0);
        for (int i = 0; i < 40; i++) begin
            cycle(1, 0, 0);
            chk("post_rst_hold", int'(phase), 0);
        end

        // Randomized traffic with occasional resets
        xr = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 6) xr = ~xr;
            cycle(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, xr,
                  ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/signal_phase_scheduler.md
Name: signal_phase_scheduler

Overview:
Timed phase scheduler for a highway / country-road intersection with a pedestrian crossing. It arbitrates three claims on the crossing: the highway (default owner), the country-road vehicle sensor, and a pedestrian push-button. It sequences green, yellow, all-red and walk phases using programmable dwell counters. Its outputs drive the lamp drivers directly and replace the untimed signal FSM at the intersection top level.

Parameters:
CW, 8, width of the dwell timer; every *_T value must be in 1..2^CW-1.
HW_MIN_T, 10, minimum highway-green dwell in cycles.
YELLOW_T, 3, yellow dwell in cycles (both roads).
ALLRED_T, 2, all-red clearance dwell in cycles.
CW_MAX_T, 20, maximum country-green dwell in cycles.
PED_T, 8, pedestrian walk dwell in cycles.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-low reset
x  input  1  country-road vehicle present (level, synchronous to clk)
ped_req  input  1  pedestrian button (pulse or level, synchronous to clk)
hw  output  2  highway lamp: 00 red, 01 yellow, 10 green
cw  output  2  country lamp, same encoding
walk  output  1  pedestrian walk lamp
ped_ack  output  1  one-cycle pulse on the first cycle of the walk phase
phase  output  3  current state code, for debug and status

Behaviour:
- Reset: one clock; reset is synchronous and active-low. At a rising edge with reset=0 the block loads state HG, clears timer to 0 and clears ped_pend. This happens from any state, including mid-phase. ped_req is ignored while reset=0.
- Outputs are Moore outputs, decoded from the state register only. They are valid in the same cycle the state is held.
- Values after reset: hw=10, cw=00, walk=0, ped_ack=0, phase=0.
- State codes for phase: HG=0, HY=1, AR1=2, CG=3, CY=4, AR2=5, PW=6. Codes 7 and up recover to HG at the next edge.
- Lamp decode per state:
  - HG: hw=10, cw=00.
  - HY: hw=01, cw=00.
  - AR1, AR2: hw=00, cw=00.
  - CG: hw=00, cw=10.
  - CY: hw=00, cw=01.
  - PW: hw=00, cw=00, walk=1.
- Timer:
  - Timer is 0 in the first cycle of every state and increments by 1 each cycle the state is held.
  - Timer clears at every state change.
  - In HG only, the timer saturates at 2^CW-1. It cannot wrap elsewhere because of the parameter bounds.
- ped_pend latch:
  - Set at any edge where ped_req=1 and the current state is not PW.
  - Cleared at the edge entering PW.
  - ped_req=1 during PW is discarded.
  - Repeated requests while ped_pend=1 have no further effect.
- Transitions (each evaluated at the rising edge):
  - HG -> HY when timer >= HW_MIN_T-1 and (x or ped_pend). Otherwise HG holds indefinitely.
  - HY -> AR1 when timer == YELLOW_T-1.
  - AR1 -> PW when ped_pend=1, else -> CG, when timer == ALLRED_T-1. Pedestrian has priority over the country road.
  - AR1 with neither x nor ped_pend set at exit (x dropped during HY or AR1) -> CG anyway. CG then exits after 1 cycle because x=0.
  - CG -> CY when x=0 or timer == CW_MAX_T-1. Minimum CG dwell is 1 cycle; maximum is CW_MAX_T cycles.
  - CY -> AR2 when timer == YELLOW_T-1.
  - PW -> AR2 when timer == PED_T-1.
  - AR2 -> HG when timer == ALLRED_T-1.
- Simultaneous events:
  - x and ped_pend both set: pedestrian is served first (PW), then AR2, then HG for the full HW_MIN_T. The country road is served on the following cycle of the sequence.
  - A ped_req arriving during CG, CY or AR2 sets ped_pend. It is served after the next HG minimum dwell.
- Fairness: the highway always receives at least HW_MIN_T cycles of green between any two non-highway phases.
- ped_ack: equals 1 exactly when state==PW and timer==0.

Test Plan:
1. Release reset, hold x=0 and ped_req=0 for 50 cycles -> phase=0, hw=10, cw=00, walk=0 every cycle.
2. Release reset with x=1 held -> dwell counts HG 10, HY 3, AR1 2, CG 20 (max cut-off), CY 3, AR2 2, then HG 10 and repeat. Check hw/cw encodings at each boundary.
3. Release reset, pulse x=1 for one cycle at cycle 15 -> HY begins at cycle 16, then AR1 2 cycles, CG exactly 1 cycle (x=0), CY 3, AR2 2, then HG with no further requests.
4. Pulse ped_req at cycle 2 after release, x=0 -> HG to cycle 9, HY 3, AR1 2, PW 8 with walk=1, ped_ack=1 only on the first PW cycle, AR2 2, then HG. A second ped_req pulse during PW produces no second walk phase.
5. Assert x=1 and pulse ped_req on the same cycle -> PW runs before CG. The sequence is HG, HY, AR1, PW, AR2, HG (10 cycles), HY, AR1, CG.
6. Drive reset=0 for one cycle at CG timer=5, with ped_pend set -> next cycle phase=0, hw=10, cw=00, walk=0, timer=0. With ped_req=0 and x=0 afterwards, HG holds indefinitely, proving ped_pend was cleared.
